// File: rtl/control_unit_if.sv
// control_unit_if: datapath-side status inputs and control strobes of the
// general-datapath controller, bundled for the controller/datapath boundary.
// master = controller view (drives strobes), slave = datapath view.
interface control_unit_if;
  logic [2:0] IR;       // opcode field of the instruction register
  logic       Aeq0;     // A == 0
  logic       Apos;     // A non-negative
  logic       Enter;    // operator key, level-sensitive
  logic       PCload;
  logic       JMPmux;
  logic       IRload;
  logic       Meminst;
  logic       MemWr;
  logic       Aload;
  logic       Sub;
  logic [1:0] Asel;     // 00 add/sub, 01 data_in, 10 RAM data
  logic       Halt;
  logic [3:0] State;    // debug view of the controller state

  modport master (
    input  IR, Aeq0, Apos, Enter,
    output PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Asel, Halt, State
  );

  modport slave (
    output IR, Aeq0, Apos, Enter,
    input  PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Asel, Halt, State
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the general datapath.
// Execute states are encoded as 8 + opcode so DECODE jumps straight to them.
// Optional feature: define CU_ENTER_RELEASE_EN to make IN wait for the
// Enter key to be released after loading A (one load per key press).
module control_unit (
  input  logic              Clock,
  input  logic              Reset,
  control_unit_if.master    cu
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd8,
    S_STORE  = 4'd9,
    S_ADD    = 4'd10,
    S_SUB    = 4'd11,
    S_IN     = 4'd12,
    S_JZ     = 4'd13,
    S_JPOS   = 4'd14,
    S_HALT   = 4'd15
  } state_e;

  state_e state_q, state_d;

`ifdef CU_ENTER_RELEASE_EN
  // Set once Enter has loaded A; IN then only waits for the key to drop.
  logic release_q, release_d;
`endif

  // State register (and release flag) with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_START;
`ifdef CU_ENTER_RELEASE_EN
      release_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
`ifdef CU_ENTER_RELEASE_EN
      release_q <= release_d;
`endif
    end
  end

  // Next-state and output decode; every output defaults to 0.
  always_comb begin
    state_d    = state_q;
`ifdef CU_ENTER_RELEASE_EN
    release_d  = release_q;
`endif
    cu.PCload  = 1'b0;
    cu.JMPmux  = 1'b0;
    cu.IRload  = 1'b0;
    cu.Meminst = 1'b0;
    cu.MemWr   = 1'b0;
    cu.Aload   = 1'b0;
    cu.Sub     = 1'b0;
    cu.Asel    = 2'b00;
    cu.Halt    = 1'b0;
    cu.State   = state_q;

    case (state_q)
      S_START: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        // Load IR from RAM[PC] and step PC.
        cu.Meminst = 1'b1;
        cu.IRload  = 1'b1;
        cu.PCload  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // IR was loaded at the end of FETCH, so the opcode is valid here.
        state_d = state_e'({1'b1, cu.IR});
      end
      S_LOAD: begin
        cu.Aload = 1'b1;
        cu.Asel  = 2'b10;
        state_d  = S_FETCH;
      end
      S_STORE: begin
        cu.MemWr = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADD: begin
        cu.Aload = 1'b1;
        state_d  = S_FETCH;
      end
      S_SUB: begin
        cu.Aload = 1'b1;
        cu.Sub   = 1'b1;
        state_d  = S_FETCH;
      end
      S_IN: begin
        cu.Asel = 2'b01;
`ifdef CU_ENTER_RELEASE_EN
        if (!release_q) begin
          cu.Aload = cu.Enter;
          if (cu.Enter) release_d = 1'b1;
        end else if (!cu.Enter) begin
          release_d = 1'b0;
          state_d   = S_FETCH;
        end
`else
        cu.Aload = cu.Enter;
        if (cu.Enter) state_d = S_FETCH;
`endif
      end
      S_JZ: begin
        cu.PCload = cu.Aeq0;
        cu.JMPmux = cu.Aeq0;
        state_d   = S_FETCH;
      end
      S_JPOS: begin
        cu.PCload = cu.Apos;
        cu.JMPmux = cu.Apos;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        // Only Reset leaves HALT.
        cu.Halt = 1'b1;
        state_d = S_HALT;
      end
      default: begin
        // Encodings 3..7 are unreachable; recover through START.
        state_d = S_START;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and randomized checks of control_unit against a
// behavioural model of the fetch/decode/execute sequence.
module tb_control_unit;

  logic Clock;
  logic Reset;
  control_unit_if cu_if ();

  control_unit dut (
    .Clock (Clock),
    .Reset (Reset),
    .cu    (cu_if.master)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int compared = 0;
  int mismatched = 0;

  // Model: where we are in the instruction sequence.
  // phase 0 = idle after reset, 1 = fetch, 2 = decode, 3 = execute, 4 = bad
  int  m_phase;
  int  m_op;         // opcode latched at decode
  bit  m_released;   // IN already loaded A, waiting for key release
  bit  m_known;      // model synchronised by a reset

  localparam logic [2:0] OP_LOAD = 3'd0, OP_STORE = 3'd1, OP_ADD = 3'd2,
                         OP_SUB = 3'd3, OP_IN = 3'd4, OP_JZ = 3'd5,
                         OP_JPOS = 3'd6, OP_HALT = 3'd7;

  // Packed observation: {State, PCload, JMPmux, IRload, Meminst, MemWr,
  //                      Aload, Sub, Asel, Halt}
  function automatic logic [14:0] observe();
    return {cu_if.State, cu_if.PCload, cu_if.JMPmux, cu_if.IRload,
            cu_if.Meminst, cu_if.MemWr, cu_if.Aload, cu_if.Sub,
            cu_if.Asel, cu_if.Halt};
  endfunction

  function automatic logic [14:0] expected(input logic aeq0, input logic apos,
                                           input logic enter);
    logic [3:0] st;
    logic pcl, jmp, irl, mi, mw, al, sb, hl;
    logic [1:0] as;
    {pcl, jmp, irl, mi, mw, al, sb, hl} = '0;
    as = 2'b00;
    st = 4'd0;
    if (m_phase == 1) begin
      st = 4'd1; irl = 1'b1; mi = 1'b1; pcl = 1'b1;
    end else if (m_phase == 2) begin
      st = 4'd2;
    end else if (m_phase == 3) begin
      st = 4'(8 + m_op);
      if (m_op == 0)      begin al = 1'b1; as = 2'b10; end
      else if (m_op == 1) mw = 1'b1;
      else if (m_op == 2) al = 1'b1;
      else if (m_op == 3) begin al = 1'b1; sb = 1'b1; end
      else if (m_op == 4) begin as = 2'b01; al = enter && !m_released; end
      else if (m_op == 5) begin pcl = aeq0; jmp = aeq0; end
      else if (m_op == 6) begin pcl = apos; jmp = apos; end
      else hl = 1'b1;
    end
    return {st, pcl, jmp, irl, mi, mw, al, sb, as, hl};
  endfunction

  task automatic advance_model(input logic rst, input logic [2:0] ir,
                               input logic enter);
    if (rst) begin
      m_phase = 0; m_released = 1'b0; m_known = 1'b1;
      return;
    end
    case (m_phase)
      0: m_phase = 1;
      1: m_phase = 2;
      2: begin m_phase = 3; m_op = int'(ir); end
      3: begin
        if (m_op == 7) m_phase = 3;
        else if (m_op == 4) begin
`ifdef CU_ENTER_RELEASE_EN
          if (!m_released) begin
            if (enter) m_released = 1'b1;
          end else if (!enter) begin
            m_released = 1'b0; m_phase = 1;
          end
`else
          if (enter) m_phase = 1;
`endif
        end else m_phase = 1;
      end
      default: m_phase = 0;
    endcase
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, step the model.
  task automatic cycle(input string tag, input logic rst, input logic [2:0] ir,
                       input logic aeq0, input logic apos, input logic enter);
    logic [14:0] obs, exp_v;
    Reset       = rst;
    cu_if.IR    = ir;
    cu_if.Aeq0  = aeq0;
    cu_if.Apos  = apos;
    cu_if.Enter = enter;
    #2;
    if (m_known) begin
      obs   = observe();
      exp_v = expected(aeq0, apos, enter);
      compared++;
      assert (obs === exp_v) else begin
        mismatched++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
    end
    @(posedge Clock);
    advance_model(rst, ir, enter);
    #1;
  endtask

  // Run one full instruction (fetch, decode, execute) with given flags.
  task automatic instr(input string tag, input logic [2:0] op,
                       input logic aeq0, input logic apos);
    cycle({tag, "_fetch"},  1'b0, op, aeq0, apos, 1'b0);
    cycle({tag, "_decode"}, 1'b0, op, aeq0, apos, 1'b0);
    cycle({tag, "_exec"},   1'b0, op, aeq0, apos, 1'b0);
  endtask

  initial begin
    Reset = 1'b1;
    cu_if.IR = 3'd0; cu_if.Aeq0 = 1'b0; cu_if.Apos = 1'b0; cu_if.Enter = 1'b0;
    m_phase = 0; m_op = 0; m_released = 1'b0; m_known = 1'b0;
    @(posedge Clock); #1;

    // Reset held two cycles (first one unchecked: state unknown before it).
    cycle("reset_a", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    cycle("reset_b", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    cycle("start",   1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Opcode sweep; START above leads into the first FETCH.
    instr("load",  OP_LOAD,  1'b0, 1'b0);
    instr("store", OP_STORE, 1'b0, 1'b0);
    instr("add",   OP_ADD,   1'b0, 1'b0);
    instr("sub",   OP_SUB,   1'b0, 1'b0);

    // Jumps taken and not taken.
    instr("jz_t",   OP_JZ,   1'b1, 1'b0);
    instr("jz_n",   OP_JZ,   1'b0, 1'b1);
    instr("jpos_t", OP_JPOS, 1'b0, 1'b1);
    instr("jpos_n", OP_JPOS, 1'b1, 1'b0);

    // IN: 4 wait cycles, one Enter cycle, then release.
    cycle("in_fetch",  1'b0, OP_IN, 1'b0, 1'b0, 1'b0);
    cycle("in_decode", 1'b0, OP_IN, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle("in_wait", 1'b0, OP_IN, 1'b0, 1'b0, 1'b0);
    cycle("in_enter", 1'b0, OP_IN, 1'b0, 1'b0, 1'b1);
`ifdef CU_ENTER_RELEASE_EN
    cycle("in_held",  1'b0, OP_IN, 1'b0, 1'b0, 1'b1);
    cycle("in_held",  1'b0, OP_IN, 1'b0, 1'b0, 1'b1);
    cycle("in_rel",   1'b0, OP_IN, 1'b0, 1'b0, 1'b0);
`endif

    // HALT for 22 cycles with noisy inputs, then reset out of it.
    cycle("halt_fetch",  1'b0, OP_HALT, 1'b0, 1'b0, 1'b0);
    cycle("halt_decode", 1'b0, OP_HALT, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++)
      cycle("halt_hold", 1'b0, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
            1'($urandom));
    cycle("halt_reset", 1'b1, OP_HALT, 1'b0, 1'b0, 1'b1);
    cycle("halt_start", 1'b0, OP_LOAD, 1'b0, 1'b0, 1'b0);
    cycle("halt_fetch2", 1'b0, OP_LOAD, 1'b0, 1'b0, 1'b0);

    // Mid-IN reset together with Enter: Aload still high that cycle.
    cycle("mid_decode", 1'b0, OP_IN, 1'b0, 1'b0, 1'b0);
    cycle("mid_in",     1'b0, OP_IN, 1'b0, 1'b0, 1'b0);
    cycle("mid_in_rst", 1'b1, OP_IN, 1'b0, 1'b0, 1'b1);
    cycle("mid_after",  1'b0, OP_STORE, 1'b0, 1'b0, 1'b1);
    // Reset while in DECODE.
    cycle("dec_fetch",  1'b0, OP_STORE, 1'b0, 1'b0, 1'b0);
    cycle("dec_rst",    1'b1, OP_STORE, 1'b0, 1'b0, 1'b0);
    cycle("dec_after",  1'b0, OP_STORE, 1'b0, 1'b0, 1'b0);

    // Randomized run with occasional resets.
    for (int i = 0; i < 600; i++)
      cycle("random", ($urandom_range(0, 24) == 0), 3'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
